// File: rtl/note_envelope.sv
// ADSR amplitude envelope applied to a 1-bit square-wave tone; emits signed
// 32-bit samples with a one-cycle write strobe once per sample tick.
module note_envelope #(
    parameter int unsigned SAMPLE_DIV   = 1042,
    parameter int unsigned PEAK         = 10000000,
    parameter int unsigned ATTACK_STEP  = 20000,
    parameter int unsigned DECAY_STEP   = 2000,
    parameter int unsigned SUSTAIN      = 6000000,
    parameter int unsigned RELEASE_STEP = 1000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        snd,
    input  logic        note_on,
    input  logic        note_off,
    input  logic        audio_out_allowed,
    output logic [31:0] sample_out,
    output logic        write_audio_out,
    output logic [23:0] env_level,
    output logic        busy
);

    localparam int unsigned LEVEL_W = 24;
    localparam int unsigned WIDE_W  = 25;
    localparam int unsigned CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [WIDE_W-1:0] PEAK_W = WIDE_W'(PEAK);
    localparam logic [WIDE_W-1:0] ATT_W  = WIDE_W'(ATTACK_STEP);
    localparam logic [WIDE_W-1:0] DEC_W  = WIDE_W'(DECAY_STEP);
    localparam logic [WIDE_W-1:0] SUS_W  = WIDE_W'(SUSTAIN);
    localparam logic [WIDE_W-1:0] REL_W  = WIDE_W'(RELEASE_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t              state;
    state_t              state_next;
    state_t              state_ev;
    logic [CNT_W-1:0]    cnt;
    logic                tick_c;
    logic [LEVEL_W-1:0]  level_next;
    logic [WIDE_W-1:0]   lvl_w;
    logic [31:0]         sample_c;

    assign tick_c   = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign lvl_w    = {1'b0, env_level};
    // Pre-update level forms the sample, so the output trails the envelope by one tick.
    assign sample_c = snd ? 32'(env_level) : (32'(0) - 32'(env_level));

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Events act immediately; the new state's level step then applies on a tick.
    always_comb begin
        state_ev   = state;
        state_next = state;
        level_next = env_level;

        if (note_on) begin
            state_ev = S_ATTACK;
        end else if (note_off && (state == S_ATTACK || state == S_DECAY ||
                                  state == S_SUSTAIN)) begin
            state_ev = S_RELEASE;
        end
        state_next = state_ev;

        if (tick_c) begin
            case (state_ev)
                S_ATTACK: begin
                    if (lvl_w + ATT_W >= PEAK_W) begin
                        level_next = LEVEL_W'(PEAK_W);
                        state_next = S_DECAY;
                    end else begin
                        level_next = LEVEL_W'(lvl_w + ATT_W);
                    end
                end
                S_DECAY: begin
                    if (lvl_w > SUS_W + DEC_W) begin
                        level_next = LEVEL_W'(lvl_w - DEC_W);
                    end else begin
                        level_next = LEVEL_W'(SUS_W);
                        state_next = S_SUSTAIN;
                    end
                end
                S_RELEASE: begin
                    if (lvl_w > REL_W) begin
                        level_next = LEVEL_W'(lvl_w - REL_W);
                    end else begin
                        level_next = '0;
                        state_next = S_IDLE;
                    end
                end
                S_IDLE:  level_next = '0;
                default: level_next = env_level;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt             <= '0;
            env_level       <= '0;
            busy            <= 1'b0;
            sample_out      <= '0;
            write_audio_out <= 1'b0;
        end else begin
            cnt             <= tick_c ? '0 : cnt + CNT_W'(1);
            env_level       <= level_next;
            busy            <= (state_next != S_IDLE);
            write_audio_out <= tick_c && audio_out_allowed;
            if (tick_c) begin
                sample_out <= sample_c;
            end
        end
    end

endmodule

// File: tb/tb_note_envelope.sv
// Bench for note_envelope: cycle-level reference model plus directed ADSR scenarios.
module tb_note_envelope;

    localparam int DIV = 4;
    localparam int PK  = 100;
    localparam int AS  = 25;
    localparam int DS  = 10;
    localparam int SUS = 60;
    localparam int RS  = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        snd = 1'b1;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic        allowed = 1'b1;
    logic [31:0] sample_out;
    logic        write_audio_out;
    logic [23:0] env_level;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    note_envelope #(
        .SAMPLE_DIV(DIV), .PEAK(PK), .ATTACK_STEP(AS), .DECAY_STEP(DS),
        .SUSTAIN(SUS), .RELEASE_STEP(RS)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .snd(snd),
        .note_on(note_on),
        .note_off(note_off),
        .audio_out_allowed(allowed),
        .sample_out(sample_out),
        .write_audio_out(write_audio_out),
        .env_level(env_level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    int m_lvl = 0;
    int m_cnt = 0;
    int m_ph  = 0;
    int m_sample = 0;
    bit m_wr = 1'b0;
    bit m_busy = 1'b0;

    always @(posedge clk) begin
        bit tick;
        if (!resetn) begin
            m_lvl = 0; m_cnt = 0; m_ph = 0; m_sample = 0; m_wr = 0; m_busy = 0;
        end else begin
            tick  = (m_cnt == DIV - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            m_wr  = tick && allowed;
            if (tick) m_sample = snd ? m_lvl : -m_lvl;
            if (note_on) m_ph = 1;
            else if (note_off && m_ph >= 1 && m_ph <= 3) m_ph = 4;
            if (tick) begin
                case (m_ph)
                    1: begin
                        m_lvl = (m_lvl + AS > PK) ? PK : m_lvl + AS;
                        if (m_lvl == PK) m_ph = 2;
                    end
                    2: begin
                        m_lvl = (m_lvl - DS < SUS) ? SUS : m_lvl - DS;
                        if (m_lvl == SUS) m_ph = 3;
                    end
                    4: begin
                        m_lvl = (m_lvl - RS < 0) ? 0 : m_lvl - RS;
                        if (m_lvl == 0) m_ph = 0;
                    end
                    0: m_lvl = 0;
                    default: ;
                endcase
            end
            m_busy = (m_ph != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_env", 32'(env_level), 32'(m_lvl));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_sample", sample_out, 32'(m_sample));
            chk("model_write", 32'(write_audio_out), 32'(m_wr));
        end
    end

    // Advance to the negedge just after the next tick edge.
    task automatic tick_wait();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_cnt != 0 && guard < 3 * DIV);
        if (m_cnt != 0) chk("tick_timeout", 32'(guard), 32'(0));
    endtask

    task automatic pulse_on();
        note_on = 1'b1; @(negedge clk); note_on = 1'b0;
    endtask

    task automatic pulse_off();
        note_off = 1'b1; @(negedge clk); note_off = 1'b0;
    endtask

    int exp_env[12] = '{25, 50, 75, 100, 90, 80, 70, 60, 60, 60, 60, 60};
    int strobes;

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_env", 32'(env_level), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_write", 32'(write_audio_out), 32'(0));
        resetn = 1'b1;

        // Full envelope with sign check in sustain.
        pulse_on();
        chk("on_busy", 32'(busy), 32'(1));
        for (int k = 0; k < 12; k++) begin
            snd = (k == 8) ? 1'b0 : 1'b1;
            tick_wait();
            chk($sformatf("env_tick%0d", k + 1), 32'(env_level), 32'(exp_env[k]));
            if (k == 4) chk("sample_lag", sample_out, 32'(100));
            if (k == 8) chk("sample_neg", sample_out, 32'hFFFF_FFC4);
            if (k == 9) chk("sample_pos", sample_out, 32'(60));
        end
        pulse_off();
        tick_wait(); chk("rel_40", 32'(env_level), 32'(40));
        tick_wait(); chk("rel_20", 32'(env_level), 32'(20));
        chk("rel_busy", 32'(busy), 32'(1));
        tick_wait(); chk("rel_0", 32'(env_level), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));

        // Retrigger from release at level 40.
        pulse_on();
        repeat (6) tick_wait();
        chk("retrig_pre", 32'(env_level), 32'(80));
        pulse_off();
        tick_wait(); tick_wait();
        chk("retrig_40", 32'(env_level), 32'(40));
        pulse_on();
        tick_wait(); chk("retrig_65", 32'(env_level), 32'(65));
        tick_wait(); chk("retrig_90", 32'(env_level), 32'(90));
        tick_wait(); chk("retrig_100", 32'(env_level), 32'(100));

        // Backpressure over three decay ticks.
        allowed = 1'b0;
        strobes = 0;
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge clk);
            if (write_audio_out) strobes++;
        end
        chk("bp_strobes", 32'(strobes), 32'(0));
        chk("bp_env", 32'(env_level), 32'(70));
        allowed = 1'b1;
        tick_wait();
        chk("bp_resume", 32'(write_audio_out), 32'(1));
        @(negedge clk);
        chk("bp_width", 32'(write_audio_out), 32'(0));

        // Reset mid-decay at level 80.
        tick_wait();
        pulse_on();
        tick_wait(); tick_wait(); tick_wait(); tick_wait();
        chk("pre_rst_env", 32'(env_level), 32'(80));
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_env", 32'(env_level), 32'(0));
        chk("mid_rst_sample", sample_out, 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_write", 32'(write_audio_out), 32'(0));
        resetn = 1'b1;
        begin
            int first = 0;
            for (int i = 1; i <= 3 * DIV; i++) begin
                @(negedge clk);
                if (write_audio_out && first == 0) first = i;
            end
            chk("first_strobe", 32'(first), 32'(4));
        end

        // Simultaneous note_on and note_off from idle.
        note_on = 1'b1; note_off = 1'b1;
        @(negedge clk);
        note_on = 1'b0; note_off = 1'b0;
        chk("simul_busy", 32'(busy), 32'(1));
        tick_wait();
        chk("simul_env", 32'(env_level), 32'(25));
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
